// File: rtl/multicycle_ctrl_fsm.sv
// Purpose : main sequencer of the multi-cycle CPU; steps each instruction through
//           IF/ID/EXE/MEM/WB, drives every datapath write-enable and mux select.
// Latency : outputs combinational from registered State/Opcode/Zero; 2..5 cycles per instr.
// Backpr. : none; the datapath always accepts. HALT parks in HALTED until Reset.
// Ports   : CLK, Reset (async, active-low), Opcode (IR[31:26]), Zero (ALU flag)
//           -> State, PCWre/IRWre/ABWre/ALUoutWre/DBWre/RegWre/mRD/mWR enables,
//              RegDst/WrSrc/PCSrc selects, InstrCount (retired instructions).
module multicycle_ctrl_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_ADDI  = 6'b000001,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_BNE   = 6'b000101,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_JAL   = 6'b000011,
    parameter logic [5:0] OP_HALT  = 6'b111111
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [5:0]  Opcode,
    input  logic        Zero,
    output logic [2:0]  State,
    output logic        PCWre,
    output logic        IRWre,
    output logic        ABWre,
    output logic        ALUoutWre,
    output logic        DBWre,
    output logic        RegWre,
    output logic [1:0]  RegDst,
    output logic [1:0]  WrSrc,
    output logic        mRD,
    output logic        mWR,
    output logic [1:0]  PCSrc,
    output logic [31:0] InstrCount
);

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE    = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100,
        S_HALTED = 3'b111
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_instr_count;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_next;
        end
    end

    // PCWre marks the last cycle of every instruction, so it doubles as the
    // retire strobe. HALT never asserts PCWre and therefore is not counted.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_instr_count <= 32'd0;
        end else if (PCWre) begin
            r_instr_count <= r_instr_count + 32'd1;
        end
    end

    always_comb begin
        w_next    = S_IF;
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        ABWre     = 1'b0;
        ALUoutWre = 1'b0;
        DBWre     = 1'b0;
        RegWre    = 1'b0;
        RegDst    = 2'b00;
        WrSrc     = 2'b00;
        mRD       = 1'b0;
        mWR       = 1'b0;
        PCSrc     = 2'b00;

        // While Reset is low every enable stays 0 so an abandoned instruction
        // cannot commit anything, independent of the held state/opcode.
        if (Reset) begin
            case (r_state)
                S_IF: begin
                    IRWre  = 1'b1;
                    w_next = S_ID;
                end
                S_ID: begin
                    ABWre = 1'b1;
                    case (Opcode)
                        OP_J: begin
                            PCWre = 1'b1;
                            PCSrc = 2'b10;
                        end
                        OP_JAL: begin
                            PCWre  = 1'b1;
                            PCSrc  = 2'b10;
                            RegWre = 1'b1;
                            RegDst = 2'b10;
                            WrSrc  = 2'b10;
                        end
                        OP_HALT: w_next = S_HALTED;
                        OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE: w_next = S_EXE;
                        // Unknown opcode retires as a NOP: just advance PC.
                        default: PCWre = 1'b1;
                    endcase
                end
                S_EXE: begin
                    ALUoutWre = 1'b1;
                    case (Opcode)
                        OP_BEQ, OP_BNE: begin
                            PCWre = 1'b1;
                            if ((Opcode == OP_BEQ && Zero) || (Opcode == OP_BNE && !Zero)) begin
                                PCSrc = 2'b01;
                            end
                        end
                        OP_LW, OP_SW: w_next = S_MEM;
                        default:      w_next = S_WB;
                    endcase
                end
                S_MEM: begin
                    if (Opcode == OP_LW) begin
                        mRD    = 1'b1;
                        DBWre  = 1'b1;
                        w_next = S_WB;
                    end else begin
                        mWR   = 1'b1;
                        PCWre = 1'b1;
                    end
                end
                S_WB: begin
                    RegWre = 1'b1;
                    PCWre  = 1'b1;
                    if (Opcode == OP_RTYPE) begin
                        RegDst = 2'b01;
                    end
                    if (Opcode == OP_LW) begin
                        WrSrc = 2'b01;
                    end
                end
                S_HALTED: w_next = S_HALTED;
                default:  w_next = S_IF;
            endcase
        end
    end

    assign State      = r_state;
    assign InstrCount = r_instr_count;

endmodule
